// File: rtl/bus_xfer_ctrl_if.sv
// ============================================================================
// Module      : bus_xfer_ctrl_if
// Description : Handshake and bus signals between the transfer controller
//               and the register file / requester. xfer_cnt exists only
//               when BUS_XFER_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_xfer_ctrl_if #(
    parameter int NREG = 8
);
    logic            req;
    logic [2:0]      src_sel;
    logic [2:0]      dst_sel;
    logic [15:0]     bus_in;
    logic [NREG-1:0] ld_bus;
    logic [NREG-1:0] wr;
    logic [15:0]     bus_out;
    logic            busy;
    logic            done;
`ifdef BUS_XFER_COUNT_EN
    logic [15:0]     xfer_cnt;

    modport slave (
        input  req, src_sel, dst_sel, bus_in,
        output ld_bus, wr, bus_out, busy, done, xfer_cnt
    );
    modport master (
        output req, src_sel, dst_sel, bus_in,
        input  ld_bus, wr, bus_out, busy, done, xfer_cnt
    );
`else
    modport slave (
        input  req, src_sel, dst_sel, bus_in,
        output ld_bus, wr, bus_out, busy, done
    );
    modport master (
        output req, src_sel, dst_sel, bus_in,
        input  ld_bus, wr, bus_out, busy, done
    );
`endif
endinterface

`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
// ============================================================================
// Module      : bus_xfer_ctrl
// Description : Register-to-register transfer sequencer over a shared
//               16-bit bus (drive, latch, write, done). Optional transfer
//               counter enabled by macro BUS_XFER_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_xfer_ctrl #(
    parameter int NREG = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    bus_xfer_ctrl_if.slave  bus
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_DRIVE = 3'd1;
    localparam logic [2:0] c_S_LATCH = 3'd2;
    localparam logic [2:0] c_S_WRITE = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [2:0]  r_src;
    logic [2:0]  r_dst;
    logic [15:0] r_hold;
    logic        w_ld_en;
    logic        w_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_src   <= 3'd0;
            r_dst   <= 3'd0;
            r_hold  <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (r_state == c_S_IDLE && bus.req) begin
                r_src <= bus.src_sel;
                r_dst <= bus.dst_sel;
            end
            if (r_state == c_S_LATCH) begin
                r_hold <= bus.bus_in;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                // Same source and destination skips the bus entirely.
                if (bus.req) begin
                    w_next = (bus.src_sel == bus.dst_sel) ? c_S_DONE : c_S_DRIVE;
                end
            end
            c_S_DRIVE: w_next = c_S_LATCH;
            c_S_LATCH: w_next = c_S_WRITE;
            c_S_WRITE: w_next = c_S_DONE;
            c_S_DONE:  w_next = c_S_IDLE;
            default:   w_next = c_S_IDLE;
        endcase
    end

    // Strobes decode straight from state so reset clears them asynchronously.
    assign w_ld_en = (r_state == c_S_DRIVE) || (r_state == c_S_LATCH);
    assign w_wr_en = (r_state == c_S_WRITE);

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_strobe
            assign bus.ld_bus[i] = w_ld_en && (r_src == 3'(i));
            assign bus.wr[i]     = w_wr_en && (r_dst == 3'(i));
        end
    endgenerate

    assign bus.bus_out = w_wr_en ? r_hold : 16'h0000;
    assign bus.busy    = (r_state != c_S_IDLE);
    assign bus.done    = (r_state == c_S_DONE);

`ifdef BUS_XFER_COUNT_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= 16'h0000;
        end else if (r_state == c_S_DONE) begin
            r_xfer_cnt <= r_xfer_cnt + 16'h0001;
        end
    end

    assign bus.xfer_cnt = r_xfer_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
// ============================================================================
// Module      : tb_bus_xfer_ctrl
// Description : Directed bench for bus_xfer_ctrl with a write scoreboard and
//               a behavioural register file feeding bus_in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_xfer_ctrl;

    localparam int NREG = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_xfer_ctrl_if #(.NREG(NREG)) bif ();

    bus_xfer_ctrl #(.NREG(NREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    typedef struct {
        logic [NREG-1:0] wr;
        logic [15:0]     data;
    } wr_exp_t;

    wr_exp_t     wq[$];
    logic [15:0] regs  [NREG];
    logic [15:0] model [NREG];
    int errors   = 0;
    int checks   = 0;
    int obs_done = 0;
    int exp_done = 0;
    int exp_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise req with the given selects; optionally record the expected outcome.
    task automatic start(input int s, input int d, input bit expect_it);
        wr_exp_t e;
        bif.req     = 1'b1;
        bif.src_sel = 3'(s);
        bif.dst_sel = 3'(d);
        if (expect_it) begin
            if (s != d) begin
                e.wr    = '0;
                e.wr[d] = 1'b1;
                e.data  = model[s];
                wq.push_back(e);
                model[d] = model[s];
            end
            exp_done++;
            exp_cnt++;
        end
    endtask

    // Register file: the strobed register drives the shared bus.
    always_comb begin
        bif.bus_in = 16'h0000;
        for (int i = 0; i < NREG; i++) begin
            if (bif.ld_bus[i]) bif.bus_in = regs[i];
        end
    end

    always @(negedge clk) begin
        wr_exp_t e;
        if (rst_n === 1'b1) begin
            chk("ld_onehot0", 32'($onehot0(bif.ld_bus)), 32'd1);
            chk("wr_onehot0", 32'($onehot0(bif.wr)), 32'd1);
            chk("ld_wr_excl", 32'((|bif.ld_bus) && (|bif.wr)), 32'd0);
            if (bif.wr === '0) chk("bus_out_idle", 32'(bif.bus_out), 32'h0);
            if (bif.done === 1'b1) obs_done++;
            if (|bif.wr) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wr", 32'(bif.wr), 32'h0);
                end else begin
                    e = wq.pop_front();
                    chk("wr_strobe", 32'(bif.wr), 32'(e.wr));
                    chk("wr_data", 32'(bif.bus_out), 32'(e.data));
                end
                for (int i = 0; i < NREG; i++) begin
                    if (bif.wr[i]) regs[i] = bif.bus_out;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREG; i++) begin
            regs[i] = 16'h1111 * 16'(i + 1);
        end
        regs[2] = 16'hA5C3;
        for (int i = 0; i < NREG; i++) model[i] = regs[i];

        rst_n       = 1'b0;
        bif.req     = 1'b0;
        bif.src_sel = 3'd0;
        bif.dst_sel = 3'd0;

        #12;
        chk("rst_busy", 32'(bif.busy), 32'h0);
        chk("rst_done", 32'(bif.done), 32'h0);
        chk("rst_ld", 32'(bif.ld_bus), 32'h0);
        chk("rst_wr", 32'(bif.wr), 32'h0);
        chk("rst_bus_out", 32'(bif.bus_out), 32'h0);
`ifdef BUS_XFER_COUNT_EN
        chk("rst_cnt", 32'(bif.xfer_cnt), 32'h0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // Basic transfer 2 -> 5, selects scrambled after acceptance.
        start(2, 5, 1'b1);
        tick();
        bif.req     = 1'b0;
        bif.src_sel = 3'd7;
        bif.dst_sel = 3'd1;
        chk("t1_ld_n1", 32'(bif.ld_bus), 32'h04);
        chk("t1_busy", 32'(bif.busy), 32'h1);
        tick();
        chk("t1_ld_n2", 32'(bif.ld_bus), 32'h04);
        tick();
        chk("t1_wr_n3", 32'(bif.wr), 32'h20);
        chk("t1_bus_n3", 32'(bif.bus_out), 32'hA5C3);
        chk("t1_ld_n3", 32'(bif.ld_bus), 32'h0);
        tick();
        chk("t1_done_n4", 32'(bif.done), 32'h1);
        chk("t1_wr_n4", 32'(bif.wr), 32'h0);
        tick();
        chk("t1_done_n5", 32'(bif.done), 32'h0);
        chk("t1_busy_n5", 32'(bif.busy), 32'h0);

        // No-op transfer 3 -> 3.
        start(3, 3, 1'b1);
        tick();
        bif.req = 1'b0;
        chk("t2_done", 32'(bif.done), 32'h1);
        chk("t2_busy", 32'(bif.busy), 32'h1);
        chk("t2_ld", 32'(bif.ld_bus), 32'h0);
        chk("t2_wr", 32'(bif.wr), 32'h0);
        tick();
        chk("t2_busy_after", 32'(bif.busy), 32'h0);
        chk("t2_done_after", 32'(bif.done), 32'h0);

        // Request raised during WRITE must be dropped.
        start(4, 1, 1'b1);
        tick();
        bif.req = 1'b0;
        tick();
        tick();
        chk("t3_wr", 32'(bif.wr), 32'h02);
        bif.req     = 1'b1;
        bif.src_sel = 3'd1;
        bif.dst_sel = 3'd0;
        tick();
        bif.req = 1'b0;
        chk("t3_done", 32'(bif.done), 32'h1);
        tick();
        chk("t3_idle", 32'(bif.busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_no_ld", 32'(bif.ld_bus), 32'h0);
            chk("t3_no_done", 32'(bif.done), 32'h0);
            chk("t3_no_busy", 32'(bif.busy), 32'h0);
        end

        // Reset in the middle of LATCH aborts the transfer.
        start(3, 4, 1'b0);
        tick();
        bif.req = 1'b0;
        tick();
        chk("t4_ld_latch", 32'(bif.ld_bus), 32'h08);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", 32'(bif.busy), 32'h0);
        chk("t4_rst_done", 32'(bif.done), 32'h0);
        chk("t4_rst_ld", 32'(bif.ld_bus), 32'h0);
        chk("t4_rst_wr", 32'(bif.wr), 32'h0);
        chk("t4_rst_bus", 32'(bif.bus_out), 32'h0);
`ifdef BUS_XFER_COUNT_EN
        chk("t4_rst_cnt", 32'(bif.xfer_cnt), 32'h0);
`endif
        exp_cnt = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("t4_idle", 32'(bif.busy), 32'h0);
        start(0, 7, 1'b1);
        tick();
        bif.req = 1'b0;
        tick();
        tick();
        chk("t4_wr", 32'(bif.wr), 32'h80);
        tick();
        chk("t4_done", 32'(bif.done), 32'h1);
        tick();

        // req held: two back-to-back transfers 4 -> 6.
        start(4, 6, 1'b1);
        start(4, 6, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 10) bif.req = 1'b0;
            chk($sformatf("t5_done_c%0d", i), 32'(bif.done), 32'((i == 4) || (i == 9)));
        end

        repeat (3) tick();
        chk("sb_empty", 32'(wq.size()), 32'h0);
        chk("done_count", 32'(obs_done), 32'(exp_done));
`ifdef BUS_XFER_COUNT_EN
        chk("xfer_cnt", 32'(bif.xfer_cnt), 32'(exp_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter: NREG, default 8, number of bus-attached registers; selects are 3 bits wide.
REQ-002 Port: clk  input  1  system clock, rising-edge active.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  1  transfer request, sampled only in IDLE.
REQ-005 Port: src_sel  input  3  index of the source register, latched when req is accepted.
REQ-006 Port: dst_sel  input  3  index of the destination register, latched when req is accepted.
REQ-007 Port: bus_in  input  16  shared bus carrying the selected register's bus output.
REQ-008 Port: ld_bus  output  NREG  one-hot load-to-bus strobes, one per register.
REQ-009 Port: wr  output  NREG  one-hot write strobes, one per register.
REQ-010 Port: bus_out  output  16  data driven to all register bus inputs.
REQ-011 Port: busy  output  1  high while a transfer is in progress (any state other than IDLE).
REQ-012 Port: done  output  1  single-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, LATCH, WRITE and DONE, with busy = (state != IDLE).
REQ-014 IDLE with req=1 at a rising edge SHALL latch src_sel/dst_sel and go to DRIVE; if src_sel==dst_sel it SHALL go to DONE instead.
REQ-015 DRIVE SHALL assert ld_bus[src] for exactly one cycle, then go to LATCH.
REQ-016 LATCH SHALL keep ld_bus[src] high, capture bus_in into a 16-bit hold register at the closing edge, then go to WRITE.
REQ-017 WRITE SHALL drive bus_out=hold and assert wr[dst] for exactly one cycle, then go to DONE.
REQ-018 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-019 Latency: req accepted at edge N gives done high in cycle N+4, or in cycle N+1 for src==dst.
REQ-020 At most one bit of ld_bus SHALL be high at any time; at most one bit of wr SHALL be high at any time; ld_bus and wr SHALL never be high in the same cycle.
REQ-021 bus_out SHALL be 16'h0000 outside WRITE and SHALL never be high-impedance.
REQ-022 req while busy=1 SHALL be ignored and not queued; input select changes after acceptance SHALL have no effect.
REQ-023 A no-op transfer (src==dst) SHALL assert no ld_bus or wr bit.
REQ-024 Back-to-back: req held high SHALL be accepted again in the cycle after DONE, since IDLE is re-entered.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, ld_bus=0, wr=0, bus_out=0, busy=0, done=0 and hold=0, independent of clk.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no wr pulse issued afterwards; the first req after deassertion SHALL start a fresh transfer.

Configuration
REQ-027 Macro BUS_XFER_COUNT_EN SHALL, when defined, add output xfer_cnt (16 bits); it increments on each done pulse, no-ops included, wraps 16'hFFFF->16'h0000 and resets to 0 with rst_n.
REQ-028 Without BUS_XFER_COUNT_EN, the xfer_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Reset then req, src=2, dst=5, bus_in=16'hA5C3 during LATCH -> ld_bus=8'h04 in cycles N+1..N+2; wr=8'h20 with bus_out=16'hA5C3 in N+3; done in N+4.
REQ-030 req with src=dst=3 -> no ld_bus or wr activity; done in N+1; busy high for one cycle.
REQ-031 req pulsed again during WRITE with src=1, dst=0 -> ignored; no second done; ld_bus stays 0 after the first transfer.
REQ-032 rst_n driven low in the middle of LATCH -> all outputs 0 asynchronously; wr never pulses; after release, req with src=0, dst=7 completes normally.
REQ-033 req held high for 12 cycles with src=4, dst=6 -> done pulses at N+4 and N+9; wr[6] pulses twice.
REQ-034 With BUS_XFER_COUNT_EN defined and the counter preloaded to 16'hFFFF through 65535 transfers -> next done sets xfer_cnt=16'h0000.
